// File: rtl/fpmul_aux_unit_if.sv
// Port bundle for the FP multiplier auxiliary unit: exponent ALU, mantissa adder,
// operand/product exponent and fraction taps, and the packed flag word.
interface fpmul_aux_unit_if #(
  parameter int ALU_W = 10,
  parameter int ADD_W = 24
);
  logic             alu_ctrl;
  logic [ALU_W-1:0] alu_a;
  logic [ALU_W-1:0] alu_b;
  logic [ALU_W-1:0] alu_y;
  logic [ADD_W-1:0] add_a;
  logic [ADD_W-1:0] add_b;
  logic [ADD_W-1:0] add_y;
  logic             cls_load;
  logic [9:0]       EAP;
  logic [7:0]       EB;
  logic [22:0]      MAP;
  logic [23:0]      MBP;
  logic [11:0]      flags;

  modport master (
    output alu_ctrl, alu_a, alu_b, add_a, add_b, cls_load, EAP, EB, MAP, MBP,
    input  alu_y, add_y, flags
  );

  modport slave (
    input  alu_ctrl, alu_a, alu_b, add_a, add_b, cls_load, EAP, EB, MAP, MBP,
    output alu_y, add_y, flags
  );
endinterface

// File: rtl/fpmul_aux_unit.sv
// Auxiliary datapath for an FP multiplier: exponent add/sub, mantissa increment,
// registered operand classification and zero-latency exponent/rounding flags.
module fpmul_aux_unit #(
  parameter int ALU_W = 10,
  parameter int ADD_W = 24
) (
  input logic          Clk,
  input logic          Rst,
  fpmul_aux_unit_if.slave bus
);

  logic [ALU_W-1:0] alu_res;
  logic [ADD_W-1:0] add_res;

  always_comb begin
    alu_res = bus.alu_ctrl ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);
    add_res = bus.add_a + bus.add_b;
  end

  assign bus.alu_y = alu_res;
  assign bus.add_y = add_res;

  // Per-operand class register, bits {dnf, zero, inf, nan}; operand 0 is A, 1 is B.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_op
      logic [7:0]  op_exp;
      logic [22:0] op_frac;
      logic        exp_ones;
      logic        exp_zero;
      logic        frac_zero;
      logic [3:0]  cls_d;
      logic [3:0]  cls_q;

      if (gi == 0) begin : gen_a
        assign op_exp  = bus.EAP[7:0];
        assign op_frac = bus.MAP;
      end else begin : gen_b
        assign op_exp  = bus.EB;
        assign op_frac = bus.MBP[22:0];
      end

      always_comb begin
        exp_ones  = &op_exp;
        exp_zero  = ~|op_exp;
        frac_zero = ~|op_frac;
        cls_d     = cls_q;
        if (bus.cls_load) begin
          cls_d = {exp_zero & ~frac_zero,
                   exp_zero &  frac_zero,
                   exp_ones &  frac_zero,
                   exp_ones & ~frac_zero};
        end
      end

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          cls_q <= 4'b0000;
        end else begin
          cls_q <= cls_d;
        end
      end
    end
  endgenerate

  logic a_nan, a_inf, a_zero, a_dnf;
  logic b_nan, b_inf, b_zero, b_dnf;
  logic res_nan, res_inf, res_zero, res_dnf;
  logic ovf, unf, rnd, mph_h;

  assign {a_dnf, a_zero, a_inf, a_nan} = gen_op[0].cls_q;
  assign {b_dnf, b_zero, b_inf, b_nan} = gen_op[1].cls_q;

  always_comb begin
    // Priority: NaN (incl. Inf*0) over Inf over Zero over Denorm.
    res_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    res_inf  = ~res_nan & (a_inf | b_inf);
    res_zero = ~res_nan & ~res_inf & (a_zero | b_zero);
    res_dnf  = ~res_nan & ~res_inf & ~res_zero & (a_dnf | b_dnf);

    // EAP is a signed biased exponent: overflow at >= 255, underflow at <= 0.
    ovf   = ~bus.EAP[9] & (bus.EAP[8:0] >= 9'd255);
    unf   = bus.EAP[9] | (bus.EAP == 10'd0);
    rnd   = bus.MBP[23];
    mph_h = &bus.MAP;
  end

  assign bus.flags = {res_zero, res_dnf, res_inf, res_nan,
                      mph_h, rnd, unf, ovf,
                      res_nan, res_inf, res_zero, res_dnf};

endmodule

// File: tb/tb_fpmul_aux_unit.sv
// Scoreboarded bench for fpmul_aux_unit: directed corner cases then random traffic,
// with expected values from an operand-class reference model.
module tb_fpmul_aux_unit;

  localparam int C_NORM = 0;
  localparam int C_NAN  = 1;
  localparam int C_INF  = 2;
  localparam int C_ZERO = 3;
  localparam int C_DEN  = 4;

  typedef struct {
    string       name;
    logic [9:0]  alu;
    logic [23:0] add;
    logic [11:0] flg;
  } exp_t;

  logic Clk;
  logic Rst;
  fpmul_aux_unit_if #(.ALU_W(10), .ADD_W(24)) bus ();

  fpmul_aux_unit #(.ALU_W(10), .ADD_W(24)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   model_ca = C_NORM;
  int   model_cb = C_NORM;
  exp_t sb_q[$];
  exp_t mon_e;
  event chk_ev;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int classify(input logic [7:0] e, input logic [22:0] f);
    if (e == 8'hFF) return (f != 0) ? C_NAN : C_INF;
    if (e == 8'h00) return (f != 0) ? C_DEN : C_ZERO;
    return C_NORM;
  endfunction

  function automatic logic [11:0] model_flags(input int ca, input int cb, input logic [9:0] eap,
                                              input logic [22:0] map, input logic [23:0] mbp);
    bit n, i, z, d;
    int e;
    n = (ca == C_NAN) || (cb == C_NAN) || (ca == C_INF && cb == C_ZERO) || (ca == C_ZERO && cb == C_INF);
    i = !n && (ca == C_INF || cb == C_INF);
    z = !n && !i && (ca == C_ZERO || cb == C_ZERO);
    d = !n && !i && !z && (ca == C_DEN || cb == C_DEN);
    e = int'(eap);
    if (e >= 512) e = e - 1024;
    return {z, d, i, n, (map == 23'h7FFFFF), mbp[23], (e <= 0), (e >= 255), n, i, z, d};
  endfunction

  task automatic check(input string nm);
    exp_t x;
    int   r;
    r = bus.alu_ctrl ? (int'(bus.alu_a) - int'(bus.alu_b)) : (int'(bus.alu_a) + int'(bus.alu_b));
    r = ((r % 1024) + 1024) % 1024;
    x.name = nm;
    x.alu  = 10'(r);
    x.add  = 24'((longint'(bus.add_a) + longint'(bus.add_b)) % 64'd16777216);
    x.flg  = model_flags(model_ca, model_cb, bus.EAP, bus.MAP, bus.MBP);
    sb_q.push_back(x);
    ->chk_ev;
    #1;
  endtask

  task automatic drive(input logic ctrl, input logic [9:0] a, input logic [9:0] b,
                       input logic [23:0] aa, input logic [23:0] ab,
                       input logic [9:0] eap, input logic [7:0] eb,
                       input logic [22:0] map, input logic [23:0] mbp);
    bus.alu_ctrl = ctrl;
    bus.alu_a    = a;
    bus.alu_b    = b;
    bus.add_a    = aa;
    bus.add_b    = ab;
    bus.EAP      = eap;
    bus.EB       = eb;
    bus.MAP      = map;
    bus.MBP      = mbp;
  endtask

  // Pulse cls_load across one rising edge and mirror the capture in the model.
  task automatic clock_load(input logic ld);
    int ca, cb;
    ca = classify(bus.EAP[7:0], bus.MAP);
    cb = classify(bus.EB, bus.MBP[22:0]);
    bus.cls_load = ld;
    @(posedge Clk);
    if (ld && !Rst) begin
      model_ca = ca;
      model_cb = cb;
    end
    #1 bus.cls_load = 1'b0;
  endtask

  function automatic logic [7:0] rand_exp();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [22:0] rand_frac();
    case ($urandom_range(0, 3))
      0: return 23'h0;
      1: return 23'h7FFFFF;
      default: return 23'($urandom);
    endcase
  endfunction

  // Monitor: pop one expectation per observation strobe and compare.
  initial begin
    forever begin
      @(chk_ev);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty: observation with no expected entry");
      end else begin
        mon_e = sb_q.pop_front();
        tests++;
        if (bus.alu_y !== mon_e.alu) begin
          fails++;
          $display("FAIL %s alu_y: got %h expected %h", mon_e.name, bus.alu_y, mon_e.alu);
        end
        tests++;
        if (bus.add_y !== mon_e.add) begin
          fails++;
          $display("FAIL %s add_y: got %h expected %h", mon_e.name, bus.add_y, mon_e.add);
        end
        tests++;
        if (bus.flags !== mon_e.flg) begin
          fails++;
          $display("FAIL %s flags: got %b expected %b", mon_e.name, bus.flags, mon_e.flg);
        end
        $display("[TB] %s alu_y=%h add_y=%h flags=%b", mon_e.name, bus.alu_y, bus.add_y, bus.flags);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst          = 1'b1;
    bus.cls_load = 1'b0;
    drive(1'b0, 10'h0, 10'h0, 24'h0, 24'h0, 10'h0, 8'h0, 23'h0, 24'h0);
    #2 check("reset_state");
    @(negedge Clk);
    Rst = 1'b0;

    // Exponent ALU and mantissa adder corners.
    drive(1'b0, 10'h082, 10'h080, 24'h7FFFFF, 24'h000001, 10'h0FF, 8'h00, 23'h0, 24'h0);
    #1 check("alu_add_082_080");
    drive(1'b1, 10'h102, 10'h07F, 24'hFFFFFF, 24'h000001, 10'h3F0, 8'h00, 23'h0, 24'h0);
    #1 check("alu_sub_102_07F");
    drive(1'b0, 10'h3FF, 10'h001, 24'h123456, 24'hEDCBA9, 10'h000, 8'h00, 23'h0, 24'h0);
    #1 check("alu_wrap_3FF_001");
    drive(1'b1, 10'h000, 10'h001, 24'h0, 24'h0, 10'h001, 8'h00, 23'h0, 24'h0);
    #1 check("alu_borrow_exp_001");

    // Inf * Zero classifies as NaN.
    @(negedge Clk);
    drive(1'b0, 10'h0, 10'h0, 24'h0, 24'h0, 10'h0FF, 8'h00, 23'h0, 24'h0);
    clock_load(1'b1);
    check("cls_inf_times_zero");

    @(negedge Clk);
    drive(1'b0, 10'h0, 10'h0, 24'h0, 24'h0, 10'h080, 8'h00, 23'h400000, 24'h0);
    clock_load(1'b1);
    check("cls_normal_times_zero");

    @(negedge Clk);
    drive(1'b0, 10'h0, 10'h0, 24'h0, 24'h0, 10'h080, 8'h00, 23'h400000, 24'h000001);
    #1 check("cls_hold_before_load");
    clock_load(1'b1);
    check("cls_normal_times_denorm");

    // Rounding flags with a fresh exponent; class bits must not change without a load.
    @(negedge Clk);
    drive(1'b0, 10'h0, 10'h0, 24'h0, 24'h0, 10'h0FF, 8'h00, 23'h7FFFFF, 24'h800000);
    #1 check("round_mph_h_ovf");
    clock_load(1'b0);
    check("cls_hold_no_load");

    // Load a NaN, then assert reset between edges.
    @(negedge Clk);
    drive(1'b0, 10'h0, 10'h0, 24'h0, 24'h0, 10'h0FF, 8'h00, 23'h000001, 24'h0);
    clock_load(1'b1);
    check("cls_nan_loaded");
    Rst = 1'b1;
    model_ca = C_NORM;
    model_cb = C_NORM;
    #1 check("async_reset_clears");
    clock_load(1'b1);
    check("reset_beats_load");
    @(negedge Clk);
    Rst = 1'b0;

    for (int it = 0; it < 150; it++) begin
      logic [9:0] eap;
      logic [23:0] mbp;
      @(negedge Clk);
      eap = {2'($urandom), rand_exp()};
      mbp = {1'($urandom), rand_frac()};
      drive(1'($urandom), 10'($urandom), 10'($urandom), 24'($urandom), 24'($urandom),
            eap, rand_exp(), rand_frac(), mbp);
      #1 check("rand_comb");
      clock_load(1'($urandom_range(0, 1)));
      check("rand_reg");
    end

    #5;
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
